// File: rtl/vector_pkg.sv
// Shared types and defaults for the vector segment drawer.
package vector_pkg;

  // Default DAC channel width and the supported range of channel widths.
  localparam int DAC_WIDTH  = 8;
  localparam int VECTOR_MIN = 4;
  localparam int VECTOR_MAX = 16;

  // Segment walker states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    STEP
  } state_t;

  // Latched segment.
  // Fields are sized for the widest supported channel.
  // Narrower builds zero-extend into them.
  typedef struct packed {
    logic [VECTOR_MAX-1:0] x0;
    logic [VECTOR_MAX-1:0] y0;
    logic [VECTOR_MAX-1:0] x1;
    logic [VECTOR_MAX-1:0] y1;
    logic                  beam;
  } seg_t;

endpackage

// File: rtl/vector_seg_draw_tick.sv
// Clock-enable tick generator: one tick every TICK_DIV enabled clocks.
module vec_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider that simply pauses while enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/vector_seg_draw.sv
// Accepts line segments and walks them with an integer Bresenham stepper,
// presenting one point per tick on the X/Y DAC channels.
module vector_seg_draw
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH = DAC_WIDTH,
  parameter int TICK_DIV  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 seg_valid,
  output logic                 seg_ready,
  input  logic [OUT_WIDTH-1:0] seg_x0,
  input  logic [OUT_WIDTH-1:0] seg_y0,
  input  logic [OUT_WIDTH-1:0] seg_x1,
  input  logic [OUT_WIDTH-1:0] seg_y1,
  input  logic                 seg_beam,
  output logic [OUT_WIDTH-1:0] x_ch,
  output logic [OUT_WIDTH-1:0] y_ch,
  output logic                 blank,
  output logic                 busy,
  output logic                 seg_done
);

  localparam int EW = OUT_WIDTH + 2;
  localparam logic signed [EW-1:0] ERR_ZERO = '0;

  state_t state, state_next;
  seg_t   seg_q;
  logic   tick, accept;

  logic [OUT_WIDTH-1:0] x_q, y_q, x_step, y_step;
  logic [OUT_WIDTH-1:0] x0_w, y0_w, x1_w, y1_w, adx, ady;
  logic signed [EW-1:0] dx_q, dy_q, err_q, err_next, dx_init, dy_init;
  logic signed [EW:0]   e2;
  logic sx_q, sy_q, blank_q, done_q;
  logic step_x, step_y, is_point, at_end;

  vec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign x0_w = seg_q.x0[OUT_WIDTH-1:0];
  assign y0_w = seg_q.y0[OUT_WIDTH-1:0];
  assign x1_w = seg_q.x1[OUT_WIDTH-1:0];
  assign y1_w = seg_q.y1[OUT_WIDTH-1:0];

  // Upper bits of the latched fields are zero.
  // So the full-width compare equals the channel-width compare.
  assign is_point = (seg_q.x0 == seg_q.x1) && (seg_q.y0 == seg_q.y1);

  // Segment set-up terms and one Bresenham step from the current point.
  always_comb begin
    adx     = (x1_w >= x0_w) ? x1_w - x0_w : x0_w - x1_w;
    ady     = (y1_w >= y0_w) ? y1_w - y0_w : y0_w - y1_w;
    dx_init = $signed({2'b00, adx});
    dy_init = -$signed({2'b00, ady});
    e2      = $signed({err_q, 1'b0});
    step_x  = e2 >= (EW+1)'(dy_q);
    step_y  = e2 <= (EW+1)'(dx_q);
    err_next = err_q + (step_x ? dy_q : ERR_ZERO) + (step_y ? dx_q : ERR_ZERO);
    x_step = x_q;
    y_step = y_q;
    if (step_x) x_step = sx_q ? x_q + OUT_WIDTH'(1) : x_q - OUT_WIDTH'(1);
    if (step_y) y_step = sy_q ? y_q + OUT_WIDTH'(1) : y_q - OUT_WIDTH'(1);
    at_end = (x_step == x1_w) && (y_step == y1_w);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and handshake.
  // Ready is held off while reset is asserted.
  always_comb begin
    state_next = state;
    seg_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        seg_ready = !rst;
        accept    = seg_valid && seg_ready;
        if (accept) state_next = START;
      end
      START: if (tick) state_next = is_point ? IDLE : STEP;
      STEP:  if (tick && at_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch segment, present start point, then advance one point per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b1;
      done_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            seg_q <= '{x0: VECTOR_MAX'(seg_x0), y0: VECTOR_MAX'(seg_y0),
                       x1: VECTOR_MAX'(seg_x1), y1: VECTOR_MAX'(seg_y1),
                       beam: seg_beam};
          end else begin
            blank_q <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            x_q     <= x0_w;
            y_q     <= y0_w;
            blank_q <= !seg_q.beam;
            dx_q    <= dx_init;
            dy_q    <= dy_init;
            err_q   <= dx_init + dy_init;
            sx_q    <= x1_w >= x0_w;
            sy_q    <= y1_w >= y0_w;
            done_q  <= is_point;
          end
        end
        STEP: begin
          if (tick) begin
            x_q    <= x_step;
            y_q    <= y_step;
            err_q  <= err_next;
            done_q <= at_end;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_ch     = x_q;
  assign y_ch     = y_q;
  assign blank    = blank_q;
  assign seg_done = done_q;
  assign busy     = (state != IDLE) || done_q || accept;

endmodule

// File: tb/tb_vector_seg_draw.sv
// Directed bench: one drawer stepping every clock, one stepping every fourth clock.
module tb_vector_seg_draw;

  logic       clk = 1'b0;
  logic       rst;
  logic       en1, en4, valid1, valid4;
  logic [7:0] seg_x0, seg_y0, seg_x1, seg_y1;
  logic       seg_beam;

  logic       ready1, blank1, busy1, done1;
  logic [7:0] x1ch, y1ch;
  logic       ready4, blank4, busy4, done4;
  logic [7:0] x4ch, y4ch;

  int total = 0;
  int bad   = 0;
  int waited;

  int steep_x [6] = '{5, 5, 4, 4, 3, 3};
  int steep_y [6] = '{5, 4, 3, 2, 1, 0};

  always #5 clk = ~clk;

  vector_seg_draw #(.OUT_WIDTH(8), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1),
    .seg_valid(valid1), .seg_ready(ready1),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .seg_beam(seg_beam),
    .x_ch(x1ch), .y_ch(y1ch), .blank(blank1), .busy(busy1), .seg_done(done1)
  );

  vector_seg_draw #(.OUT_WIDTH(8), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enable(en4),
    .seg_valid(valid4), .seg_ready(ready4),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .seg_beam(seg_beam),
    .x_ch(x4ch), .y_ch(y4ch), .blank(blank4), .busy(busy4), .seg_done(done4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a segment to dut1 (sel=0) or dut4 (sel=1).
  // Returns on the negedge after the accepting edge.
  task automatic applyStimulus(input bit sel, input int x0, input int y0,
                               input int x1, input int y1, input bit beam);
    seg_x0 = 8'(x0); seg_y0 = 8'(y0); seg_x1 = 8'(x1); seg_y1 = 8'(y1);
    seg_beam = beam;
    if (sel) valid4 = 1'b1; else valid1 = 1'b1;
    #1;
    checkOutput("accept_ready", sel ? ready4 : ready1, 1);
    checkOutput("accept_busy",  sel ? busy4  : busy1,  1);
    stepClk();
    valid1 = 1'b0;
    valid4 = 1'b0;
  endtask

  task automatic checkPoint(input string tag, input int ex, input int ey,
                            input bit eblank, input bit edone);
    checkOutput({tag, "_x"},     x1ch,   ex);
    checkOutput({tag, "_y"},     y1ch,   ey);
    checkOutput({tag, "_blank"}, blank1, eblank);
    checkOutput({tag, "_done"},  done1,  edone);
    checkOutput({tag, "_busy"},  busy1,  1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; en1 = 1'b1; en4 = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    seg_x0 = '0; seg_y0 = '0; seg_x1 = '0; seg_y1 = '0; seg_beam = 1'b0;
    @(negedge clk);

    $display("[TB] reset");
    repeat (3) stepClk();
    checkOutput("rst_x",      x1ch,   0);
    checkOutput("rst_y",      y1ch,   0);
    checkOutput("rst_blank",  blank1, 1);
    checkOutput("rst_busy",   busy1,  0);
    checkOutput("rst_done",   done1,  0);
    checkOutput("rst_ready1", ready1, 0);
    checkOutput("rst_ready4", ready4, 0);
    rst = 1'b0;
    stepClk();
    checkOutput("post_rst_ready", ready1, 1);
    checkOutput("post_rst_blank", blank1, 1);
    checkOutput("post_rst_busy",  busy1,  0);

    $display("[TB] horizontal");
    applyStimulus(0, 10, 20, 14, 20, 1);
    checkOutput("horiz_start_ready", ready1, 0);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkPoint("horiz", 10 + i, 20, 0, i == 4);
    end
    stepClk();
    checkOutput("horiz_after_blank", blank1, 1);
    checkOutput("horiz_after_done",  done1,  0);
    checkOutput("horiz_after_busy",  busy1,  0);

    $display("[TB] diagonal");
    applyStimulus(0, 0, 0, 3, 3, 1);
    for (int i = 0; i < 4; i++) begin
      stepClk();
      checkPoint("diag", i, i, 0, i == 3);
    end
    stepClk();

    $display("[TB] steep");
    applyStimulus(0, 5, 5, 3, 0, 0);
    for (int i = 0; i < 6; i++) begin
      stepClk();
      checkPoint("steep", steep_x[i], steep_y[i], 1, i == 5);
    end
    stepClk();
    checkOutput("steep_after_done", done1, 0);

    $display("[TB] zero length and back-to-back");
    applyStimulus(0, 7, 7, 7, 7, 1);
    stepClk();
    checkPoint("zero", 7, 7, 0, 1);
    applyStimulus(0, 1, 2, 2, 2, 1);
    checkOutput("b2b_blank_kept", blank1, 0);
    checkOutput("b2b_busy",       busy1,  1);
    checkOutput("b2b_done_clr",   done1,  0);
    stepClk();
    checkPoint("b2b", 1, 2, 0, 0);
    stepClk();
    checkPoint("b2b", 2, 2, 0, 1);
    stepClk();

    $display("[TB] reset mid-segment");
    applyStimulus(0, 0, 0, 9, 0, 1);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkPoint("midrst", i, 0, 0, 0);
    end
    rst = 1'b1;
    stepClk();
    checkOutput("midrst_x",     x1ch,   0);
    checkOutput("midrst_blank", blank1, 1);
    checkOutput("midrst_busy",  busy1,  0);
    checkOutput("midrst_done",  done1,  0);
    checkOutput("midrst_ready", ready1, 0);
    rst = 1'b0;
    stepClk();
    applyStimulus(0, 3, 3, 4, 3, 1);
    stepClk();
    checkPoint("after_rst", 3, 3, 0, 0);
    stepClk();
    checkPoint("after_rst", 4, 3, 0, 1);
    stepClk();

    $display("[TB] divided tick with enable gap");
    applyStimulus(1, 0, 0, 2, 0, 1);
    waited = 0;
    while (blank4 !== 1'b0 && waited < 8) begin
      stepClk();
      waited++;
    end
    checkOutput("t4_first_blank", blank4, 0);
    checkOutput("t4_first_x",     x4ch,   0);
    checkOutput("t4_first_y",     y4ch,   0);
    checkOutput("t4_first_done",  done4,  0);
    for (int k = 0; k < 3; k++) begin
      stepClk();
      checkOutput("t4_hold0_x", x4ch, 0);
    end
    stepClk();
    checkOutput("t4_second_x",    x4ch,  1);
    checkOutput("t4_second_busy", busy4, 1);
    stepClk();
    checkOutput("t4_pre_gap_x", x4ch, 1);
    en4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      stepClk();
      checkOutput("t4_gap_x", x4ch, 1);
    end
    checkOutput("t4_gap_done", done4, 0);
    en4 = 1'b1;
    stepClk();
    checkOutput("t4_resume1_x", x4ch, 1);
    stepClk();
    checkOutput("t4_resume2_x", x4ch, 1);
    stepClk();
    checkOutput("t4_end_x",     x4ch,   2);
    checkOutput("t4_end_y",     y4ch,   0);
    checkOutput("t4_end_done",  done4,  1);
    checkOutput("t4_end_ready", ready4, 1);
    stepClk();
    checkOutput("t4_idle_done",  done4,  0);
    checkOutput("t4_idle_busy",  busy4,  0);
    checkOutput("t4_idle_blank", blank4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
